// File: rtl/flash_responder.sv
// flash_responder: chip side of a CFI/Intel parallel NOR flash bus, backed by an on-chip halfword array.
// Define FLASH_RESPONDER_TIMING_CHECK_EN to add the sticky timing_err bus-protocol monitor.
module flash_responder #(
  parameter int          ADDR_WIDTH   = 10,
  parameter int          BLOCK_AW     = 6,
  parameter int          PROG_CYCLES  = 8,
  parameter int          ERASE_CYCLES = 32,
  parameter logic [15:0] DEVICE_ID    = 16'h0018
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [22:0] flash_a,
  inout  wire  [15:0] flash_d,
  input  logic        flash_ce_n,
  input  logic        flash_oe_n,
  input  logic        flash_we_n,
  input  logic        flash_rp_n,
  input  logic        flash_vpen,
  input  logic        flash_byte_n,
`ifdef FLASH_RESPONDER_TIMING_CHECK_EN
  output logic        timing_err,
`endif
  output logic        busy
);

  // state       | meaning
  // READ_ARRAY  | reads return array contents
  // READ_STATUS | reads return status register
  // READ_ID     | reads return manufacturer / device id
  // PROG_SETUP  | next strobe supplies program address and data
  // ERASE_SETUP | next strobe must be the D0 confirm
  // BUSY_PROG   | program timer running
  // BUSY_ERASE  | erase timer running
  // ERASE_SWEEP | one word of the block erased per clk
  typedef enum logic [2:0] {
    READ_ARRAY, READ_STATUS, READ_ID, PROG_SETUP,
    ERASE_SETUP, BUSY_PROG, BUSY_ERASE, ERASE_SWEEP
  } state_t;

  localparam int DEPTH   = 1 << ADDR_WIDTH;
  localparam int CNT_MAX = (PROG_CYCLES > ERASE_CYCLES) ? PROG_CYCLES : ERASE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t                state_q, state_d;
  logic [15:0]           mem_n [DEPTH];
  logic                  prev_ce_n, prev_we_n;
  logic [ADDR_WIDTH-1:0] prev_idx, op_idx, rd_idx;
  logic [15:0]           prev_d, op_data, rd_q;
  logic [CW-1:0]         cnt;
  logic                  sr5, sr4, sr3;
  logic                  strobe;
  logic [7:0]            cmd, status;
  logic                  ld_prog, ld_erase, commit, sweep_wr;
  logic                  set_sr3, set_sr4, set_sr5, clr_sr;
  logic                  unused;

  assign rd_idx  = flash_a[ADDR_WIDTH:1];
  assign unused  = ^{flash_byte_n, flash_a[22:ADDR_WIDTH+1], flash_a[0]};
  assign strobe  = !prev_we_n && flash_we_n && !prev_ce_n;
  assign cmd     = prev_d[7:0];
  assign busy    = (state_q == BUSY_PROG) || (state_q == BUSY_ERASE) || (state_q == ERASE_SWEEP);
  assign status  = {~busy, 1'b0, sr5, sr4, sr3, 3'b000};
  assign flash_d = (!flash_ce_n && !flash_oe_n && flash_we_n && flash_rp_n) ? rd_q : 16'hzzzz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_ce_n <= 1'b1;
      prev_we_n <= 1'b1;
      prev_idx  <= '0;
      prev_d    <= '0;
    end else begin
      prev_ce_n <= flash_ce_n;
      prev_we_n <= flash_we_n;
      prev_idx  <= flash_a[ADDR_WIDTH:1];
      prev_d    <= flash_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= READ_ARRAY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ld_prog  = 1'b0;
    ld_erase = 1'b0;
    commit   = 1'b0;
    sweep_wr = 1'b0;
    set_sr3  = 1'b0;
    set_sr4  = 1'b0;
    set_sr5  = 1'b0;
    clr_sr   = 1'b0;
    if (!flash_rp_n) begin
      state_d = READ_ARRAY;
    end else begin
      case (state_q)
        READ_ARRAY, READ_STATUS, READ_ID: begin
          if (strobe) begin
            case (cmd)
              8'hFF:        state_d = READ_ARRAY;
              8'h70:        state_d = READ_STATUS;
              8'h90:        state_d = READ_ID;
              8'h50:        clr_sr  = 1'b1;
              8'h40, 8'h10: state_d = PROG_SETUP;
              8'h20:        state_d = ERASE_SETUP;
              default:      ;
            endcase
          end
        end
        PROG_SETUP: begin
          if (strobe) begin
            if (!flash_vpen) begin
              set_sr3 = 1'b1;
              set_sr4 = 1'b1;
              state_d = READ_STATUS;
            end else begin
              ld_prog = 1'b1;
              state_d = BUSY_PROG;
            end
          end
        end
        ERASE_SETUP: begin
          if (strobe) begin
            state_d = READ_STATUS;
            if (cmd != 8'hD0) begin
              set_sr4 = 1'b1;
              set_sr5 = 1'b1;
            end else if (!flash_vpen) begin
              set_sr3 = 1'b1;
              set_sr5 = 1'b1;
            end else begin
              ld_erase = 1'b1;
              state_d  = BUSY_ERASE;
            end
          end
        end
        BUSY_PROG: begin
          if (cnt == '0) begin
            commit  = 1'b1;
            state_d = READ_STATUS;
          end
        end
        BUSY_ERASE: begin
          if (cnt == '0) state_d = ERASE_SWEEP;
        end
        ERASE_SWEEP: begin
          sweep_wr = 1'b1;
          if (&op_idx[BLOCK_AW-1:0]) state_d = READ_STATUS;
        end
        default: state_d = READ_ARRAY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      op_idx  <= '0;
      op_data <= '0;
      sr5     <= 1'b0;
      sr4     <= 1'b0;
      sr3     <= 1'b0;
      rd_q    <= '0;
    end else if (!flash_rp_n) begin
      cnt  <= '0;
      sr5  <= 1'b0;
      sr4  <= 1'b0;
      sr3  <= 1'b0;
      rd_q <= '0;
    end else begin
      if (ld_prog) begin
        cnt     <= CW'(PROG_CYCLES - 1);
        op_idx  <= prev_idx;
        op_data <= prev_d;
      end else if (ld_erase) begin
        cnt    <= CW'(ERASE_CYCLES - 1);
        op_idx <= {prev_idx[ADDR_WIDTH-1:BLOCK_AW], {BLOCK_AW{1'b0}}};
      end else begin
        if (cnt != '0) cnt <= cnt - CW'(1);
        if (sweep_wr) op_idx <= op_idx + ADDR_WIDTH'(1);
      end
      if (clr_sr) begin
        sr5 <= 1'b0;
        sr4 <= 1'b0;
        sr3 <= 1'b0;
      end
      if (set_sr5) sr5 <= 1'b1;
      if (set_sr4) sr4 <= 1'b1;
      if (set_sr3) sr3 <= 1'b1;
      case (state_q)
        READ_ARRAY: rd_q <= ~mem_n[rd_idx];
        READ_ID:    rd_q <= rd_idx[0] ? DEVICE_ID : 16'h0089;
        default:    rd_q <= {8'h00, status};
      endcase
    end
  end

  // Stored inverted so zero-initialised storage reads as erased 16'hFFFF.
  always_ff @(posedge clk) begin
    if (commit)        mem_n[op_idx] <= mem_n[op_idx] | ~op_data;
    else if (sweep_wr) mem_n[op_idx] <= '0;
  end

`ifdef FLASH_RESPONDER_TIMING_CHECK_EN
  logic [1:0] we_low;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_low     <= '0;
      timing_err <= 1'b0;
    end else if (!flash_rp_n) begin
      we_low     <= '0;
      timing_err <= 1'b0;
    end else begin
      if (flash_we_n)          we_low <= 2'd0;
      else if (we_low != 2'd3) we_low <= we_low + 2'd1;
      if ((!flash_ce_n && !flash_oe_n && !flash_we_n) || (strobe && we_low < 2'd3))
        timing_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_flash_responder.sv
// tb_flash_responder: table vectors, hand sequences for busy timing and abort, and randomized
// command traffic checked against a command-level model of the flash.
module tb_flash_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [22:0] flash_a;
  wire  [15:0] flash_d;
  logic [15:0] d_drv;
  logic        d_en;
  logic        ce_n, oe_n, we_n, rp_n, vpen, byte_n;
  logic        busy;
`ifdef FLASH_RESPONDER_TIMING_CHECK_EN
  logic        timing_err;
`endif

  assign flash_d = d_en ? d_drv : 16'hzzzz;
  always #5 clk = ~clk;

  flash_responder dut (
    .clk(clk), .rst(rst), .flash_a(flash_a), .flash_d(flash_d),
    .flash_ce_n(ce_n), .flash_oe_n(oe_n), .flash_we_n(we_n), .flash_rp_n(rp_n),
    .flash_vpen(vpen), .flash_byte_n(byte_n),
`ifdef FLASH_RESPONDER_TIMING_CHECK_EN
    .timing_err(timing_err),
`endif
    .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // command-level model: mode 0 array, 1 status, 2 id, 3 program setup, 4 erase setup
  logic [15:0] m [1024];
  int          md;
  logic        msr3, msr4, msr5;
  bit          model_on;

  function automatic logic [15:0] model_read(input logic [22:0] a);
    logic [9:0] idx;
    idx = a[10:1];
    if (md == 0) return m[idx];
    if (md == 2) return idx[0] ? 16'h0018 : 16'h0089;
    return {8'h00, 1'b1, 1'b0, msr5, msr4, msr3, 3'b000};
  endfunction

  task automatic model_write(input logic [22:0] a, input logic [15:0] d, input logic v);
    logic [9:0] idx;
    int base;
    idx = a[10:1];
    case (md)
      3: begin
        if (!v) begin msr3 = 1; msr4 = 1; end
        else m[idx] = m[idx] & d;
        md = 1;
      end
      4: begin
        if (d[7:0] != 8'hD0) begin msr4 = 1; msr5 = 1; end
        else if (!v) begin msr3 = 1; msr5 = 1; end
        else begin
          base = int'(idx) / 64 * 64;
          for (int i = 0; i < 64; i++) m[base + i] = 16'hFFFF;
        end
        md = 1;
      end
      default: begin
        case (d[7:0])
          8'hFF: md = 0;
          8'h70: md = 1;
          8'h90: md = 2;
          8'h50: begin msr3 = 0; msr4 = 0; msr5 = 0; end
          8'h40, 8'h10: md = 3;
          8'h20: md = 4;
          default: ;
        endcase
      end
    endcase
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [22:0] a, input logic [15:0] d, input logic v);
    @(negedge clk);
    flash_a = a; d_drv = d; d_en = 1'b1; vpen = v; ce_n = 1'b0; we_n = 1'b0;
    repeat (3) @(negedge clk);
    we_n = 1'b1;
    @(negedge clk);
    ce_n = 1'b1; d_en = 1'b0;
    if (model_on) model_write(a, d, v);
  endtask

  task automatic bus_read(input logic [22:0] a, output logic [15:0] d);
    @(negedge clk);
    flash_a = a; ce_n = 1'b0; oe_n = 1'b0;
    repeat (2) @(negedge clk);
    d = flash_d;
    ce_n = 1'b1; oe_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", n);
    end
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  localparam int K_WR = 0, K_RD = 1, K_WAIT = 2;
  typedef struct {
    int          kind;
    logic [22:0] a;
    logic [15:0] d;
    logic        v;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int k, input logic [22:0] a, input logic [15:0] d,
                     input logic v, input logic [15:0] e);
    vec_t t;
    t.kind = k; t.a = a; t.d = d; t.v = v; t.exp = e;
    tbl.push_back(t);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got;
    logic [22:0] a;
    logic [7:0]  c;
    logic        v;
    int          n, r;

    rst = 1'b1; ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1; rp_n = 1'b1;
    vpen = 1'b1; byte_n = 1'b1; d_en = 1'b0; d_drv = '0; flash_a = '0;
    for (int i = 0; i < 1024; i++) m[i] = 16'hFFFF;
    md = 0; msr3 = 0; msr4 = 0; msr5 = 0; model_on = 1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_int("reset_busy", int'(busy), 0);

    add(K_RD, 23'h000, 16'h0000, 1, 16'hFFFF);
    add(K_RD, 23'h002, 16'h0000, 1, 16'hFFFF);
    add(K_WR, 23'h000, 16'h0090, 1, 16'h0000);
    add(K_RD, 23'h000, 16'h0000, 1, 16'h0089);
    add(K_RD, 23'h002, 16'h0000, 1, 16'h0018);
    add(K_RD, 23'h802, 16'h0000, 1, 16'h0018);
    add(K_WR, 23'h000, 16'h12FF, 1, 16'h0000);
    add(K_RD, 23'h000, 16'h0000, 1, 16'hFFFF);
    add(K_WR, 23'h000, 16'h0040, 1, 16'h0000);
    add(K_WR, 23'h010, 16'h1234, 1, 16'h0000);
    add(K_RD, 23'h010, 16'h0000, 1, 16'h0000);
    add(K_WAIT, 23'h0, 16'h0000, 1, 16'h0000);
    add(K_RD, 23'h010, 16'h0000, 1, 16'h0080);
    add(K_WR, 23'h000, 16'h00FF, 1, 16'h0000);
    add(K_RD, 23'h010, 16'h0000, 1, 16'h1234);
    add(K_WR, 23'h000, 16'h0010, 1, 16'h0000);
    add(K_WR, 23'h010, 16'hFF0F, 1, 16'h0000);
    add(K_WAIT, 23'h0, 16'h0000, 1, 16'h0000);
    add(K_WR, 23'h000, 16'h00FF, 1, 16'h0000);
    add(K_RD, 23'h010, 16'h0000, 1, 16'h1204);
    add(K_WR, 23'h000, 16'h0040, 0, 16'h0000);
    add(K_WR, 23'h010, 16'hAAAA, 0, 16'h0000);
    add(K_RD, 23'h000, 16'h0000, 0, 16'h0098);
    add(K_WR, 23'h000, 16'h0050, 1, 16'h0000);
    add(K_RD, 23'h000, 16'h0000, 1, 16'h0080);
    add(K_WR, 23'h000, 16'h00FF, 1, 16'h0000);
    add(K_RD, 23'h010, 16'h0000, 1, 16'h1204);
    add(K_WR, 23'h000, 16'h0040, 1, 16'h0000);
    add(K_WR, 23'h810, 16'h00FF, 1, 16'h0000);
    add(K_WAIT, 23'h0, 16'h0000, 1, 16'h0000);
    add(K_WR, 23'h000, 16'h00FF, 1, 16'h0000);
    add(K_RD, 23'h010, 16'h0000, 1, 16'h0004);
    add(K_WR, 23'h000, 16'h0020, 1, 16'h0000);
    add(K_WR, 23'h000, 16'h00AB, 1, 16'h0000);
    add(K_RD, 23'h000, 16'h0000, 1, 16'h00B0);
    add(K_WR, 23'h000, 16'h0050, 1, 16'h0000);
    add(K_RD, 23'h000, 16'h0000, 1, 16'h0080);
    add(K_WR, 23'h000, 16'h0020, 0, 16'h0000);
    add(K_WR, 23'h000, 16'h00D0, 0, 16'h0000);
    add(K_RD, 23'h000, 16'h0000, 0, 16'h00A8);
    add(K_WR, 23'h000, 16'h0050, 1, 16'h0000);
    add(K_WR, 23'h000, 16'h0033, 1, 16'h0000);
    add(K_RD, 23'h000, 16'h0000, 1, 16'h0080);
    add(K_WR, 23'h000, 16'hAB90, 1, 16'h0000);
    add(K_RD, 23'h002, 16'h0000, 1, 16'h0018);
    add(K_WR, 23'h000, 16'h00FF, 1, 16'h0000);
    add(K_RD, 23'h010, 16'h0000, 1, 16'h0004);

    foreach (tbl[i]) begin
      case (tbl[i].kind)
        K_WR:    bus_write(tbl[i].a, tbl[i].d, tbl[i].v);
        K_RD:    begin
          bus_read(tbl[i].a, got);
          check16($sformatf("vec[%0d] rd %h", i, tbl[i].a), got, tbl[i].exp);
        end
        default: wait_idle();
      endcase
    end

    // program busy length, read of status mid-program
    bus_write(23'h000, 16'h0040, 1);
    bus_write(23'h200, 16'h5A5A, 1);
    n = 0;
    while (busy && n < 2000) begin
      n++;
      if (n == 2) begin flash_a = 23'h200; ce_n = 1'b0; oe_n = 1'b0; end
      if (n == 5) check16("prog_busy_read", flash_d, 16'h0000);
      @(negedge clk);
    end
    check_int("prog_busy_cycles", n, 8);
    @(negedge clk);
    check16("prog_done_status", flash_d, 16'h0080);
    ce_n = 1'b1; oe_n = 1'b1;

    // full block erase
    bus_write(23'h000, 16'h0040, 1);
    bus_write(23'h080, 16'h0F0F, 1);
    wait_idle();
    bus_write(23'h000, 16'h0020, 1);
    bus_write(23'h010, 16'h00D0, 1);
    count_busy(n);
    check_int("erase_busy_cycles", n, 96);
    bus_write(23'h000, 16'h00FF, 1);
    bus_read(23'h000, got); check16("erase_word0", got, 16'hFFFF);
    bus_read(23'h010, got); check16("erase_word8", got, 16'hFFFF);
    bus_read(23'h07E, got); check16("erase_word63", got, 16'hFFFF);
    bus_read(23'h080, got); check16("erase_next_block", got, 16'h0F0F);

    // rp_n abort partway through the sweep
    bus_write(23'h000, 16'h0040, 1);
    bus_write(23'h00A, 16'h1111, 1);
    wait_idle();
    bus_write(23'h000, 16'h0040, 1);
    bus_write(23'h040, 16'h2222, 1);
    wait_idle();
    model_on = 0;
    bus_write(23'h000, 16'h0020, 1);
    bus_write(23'h000, 16'h00D0, 1);
    repeat (42) @(negedge clk);
    check_int("sweep_busy", int'(busy), 1);
    rp_n = 1'b0;
    @(negedge clk);
    check_int("abort_busy", int'(busy), 0);
    rp_n = 1'b1;
    for (int i = 0; i < 10; i++) m[i] = 16'hFFFF;
    md = 0; msr3 = 0; msr4 = 0; msr5 = 0; model_on = 1;
    bus_read(23'h00A, got); check16("abort_swept_word", got, 16'hFFFF);
    bus_read(23'h040, got); check16("abort_kept_word", got, 16'h2222);
    bus_read(23'h080, got); check16("abort_other_block", got, 16'h0F0F);

    // randomized traffic against the model
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      a = 23'($urandom);
      if (r <= 3) begin
        bus_read(a, got);
        check16($sformatf("rand_rd[%0d] %h", it, a), got, model_read(a));
      end else if (r <= 5) begin
        case ($urandom_range(0, 4))
          0: c = 8'hFF;
          1: c = 8'h70;
          2: c = 8'h90;
          3: c = 8'h50;
          default: c = 8'($urandom);
        endcase
        bus_write(a, {8'($urandom), c}, 1'b1);
        wait_idle();
      end else if (r <= 8) begin
        v = ($urandom_range(0, 4) != 0);
        bus_write(a, 16'h0040, 1'b1);
        bus_write(23'($urandom), 16'($urandom), v);
        wait_idle();
      end else begin
        v = ($urandom_range(0, 3) != 0);
        bus_write(a, 16'h0020, 1'b1);
        bus_write(23'($urandom), ($urandom_range(0, 3) != 0) ? 16'h00D0 : 16'($urandom), v);
        wait_idle();
      end
    end
    check_int("final_busy", int'(busy), 0);
`ifdef FLASH_RESPONDER_TIMING_CHECK_EN
    check_int("timing_err_clean", int'(timing_err), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
